// File: rtl/uart_dbg_master_pkg.sv
// rtl/uart_dbg_master_pkg.sv - shared constants and state encodings for uart_dbg_master
//   CMD_WRITE / CMD_READ : frame command bytes
//   RESP_ACK / RESP_NAK  : single-byte responses
//   TIMEOUT_BIT_TIMES    : inter-byte gap limit used when UART_DBG_TIMEOUT_EN is defined
//   state_t / tx_state_t : parser and serialiser state encodings
package uart_dbg_master_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_ACK  = 8'h06;
  localparam logic [7:0] RESP_NAK  = 8'h15;

  localparam int TIMEOUT_BIT_TIMES = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 LSB-first serial byte receiver
//   clk, rst   : system clock, synchronous active-high reset
//   rx         : asynchronous serial input
//   data       : last received byte, valid while valid is high
//   valid      : one-cycle pulse, byte received with a good stop bit
//   frame_err  : one-cycle pulse, byte discarded because its stop bit was 0
module uart_byte_rx #(
  parameter int BAUD_CNT_MAX = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] SAMPLE_PT = 16'(BAUD_CNT_MAX / 2 - 1);

  logic [3:0]  rx_sync;
  logic        rx_line;
  logic        rx_prev;
  logic        armed;
  logic        active;
  logic [15:0] cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;

  assign rx_line = rx_sync[2];
  assign rx_prev = rx_sync[3];
  assign data    = shreg;

  // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  // After reset the receiver stays unarmed until the line has been high
  // for a full bit time, so a byte cut by reset cannot be mistaken for a
  // start edge; cnt doubles as that idle-high counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync   <= 4'h0;
      armed     <= 1'b0;
      active    <= 1'b0;
      cnt       <= 16'd0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[2:0], rx};
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (!armed) begin
        if (!rx_line) begin
          cnt <= 16'd0;
        end else if (cnt == BAUD_LAST) begin
          armed <= 1'b1;
          cnt   <= 16'd0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else if (!active) begin
        if (rx_prev && !rx_line) begin
          active  <= 1'b1;
          cnt     <= 16'd0;
          bit_cnt <= 4'd0;
        end
      end else begin
        if (cnt == BAUD_LAST) begin
          cnt     <= 16'd0;
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          cnt <= cnt + 16'd1;
        end
        if (cnt == SAMPLE_PT) begin
          if (bit_cnt == 4'd0) begin
            // start bit no longer low at mid-bit: treat as a glitch
            if (rx_line) begin
              active <= 1'b0;
              cnt    <= 16'd0;
            end
          end else if (bit_cnt <= 4'd8) begin
            shreg <= {rx_line, shreg[7:1]};
          end else begin
            // stop bit sampled; free up early so a back-to-back start is caught
            active    <= 1'b0;
            cnt       <= 16'd0;
            bit_cnt   <= 4'd0;
            valid     <= rx_line;
            frame_err <= !rx_line;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_dbg_master.sv
// rtl/uart_dbg_master.sv - UART command parser driving a simple 32-bit read/write bus
//   clk, rst   : system clock, synchronous active-high reset
//   uart_rx    : serial command input (8N1)
//   uart_tx    : serial response output (8N1, idles high)
//   wr_en_o    : one-cycle bus write strobe, wr_addr_o / wr_data_o valid with it
//   rd_addr_o  : read address, rd_data_i valid RD_LATENCY cycles after it changes
//   busy_o     : high while a frame is being handled
//   err_o      : one-cycle pulse on a rejected frame
//   UART_DBG_TIMEOUT_EN : when defined, a 16-bit-time gap inside a frame aborts it with NAK
module uart_dbg_master
  import uart_dbg_master_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [31:0] rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
  localparam logic [7:0]  RD_WAIT_LAST = 8'(RD_LATENCY);

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;

  state_t      state, state_next;
  tx_state_t   tx_state, tx_next;

  logic [1:0]  byte_cnt;
  logic        is_rd;
  logic [31:0] addr_sh;
  logic [31:0] data_sh;
  logic [31:0] resp_data;
  logic [1:0]  resp_rem;
  logic [7:0]  wait_cnt;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic        tx_done_q;
  logic        tx_byte_done;
  logic        cmd_ok;
  logic        in_frame;
  logic        frame_last;
  logic        timeout;

  uart_byte_rx #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  assign cmd_ok       = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
  assign in_frame     = (state == ST_ADDR) || (state == ST_DATA);
  assign frame_last   = rx_valid && (byte_cnt == 2'd3);
  assign tx_byte_done = (tx_state == TX_STOP) && (tx_cnt == BAUD_LAST);

`ifdef UART_DBG_TIMEOUT_EN
  localparam int GAP_LIMIT = TIMEOUT_BIT_TIMES * BAUD_CNT_MAX;

  // Counts idle cycles since the last accepted byte of the current frame.
  logic [20:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (rst || !in_frame || rx_valid) begin
      gap_cnt <= 21'd0;
    end else if (!timeout) begin
      gap_cnt <= gap_cnt + 21'd1;
    end
  end

  assign timeout = in_frame && !rx_valid && !rx_ferr && (gap_cnt == 21'(GAP_LIMIT - 1));
`else
  assign timeout = 1'b0;
`endif

  // ---------------- parser FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          state_next = cmd_ok ? ST_ADDR : ST_RESP;
        end
      end
      ST_ADDR: begin
        if (rx_ferr) begin
          state_next = ST_IDLE;
        end else if (timeout) begin
          state_next = ST_RESP;
        end else if (frame_last) begin
          state_next = is_rd ? ST_RD_WAIT : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_ferr) begin
          state_next = ST_IDLE;
        end else if (timeout) begin
          state_next = ST_RESP;
        end else if (frame_last) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE:   state_next = ST_RESP;
      ST_RD_WAIT: begin
        if (wait_cnt == RD_WAIT_LAST) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // tx_done_q lags the end of the last stop bit by one cycle
        if (tx_done_q) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state != ST_IDLE);
    wr_en_o = (state == ST_WRITE);
    err_o   = (rx_ferr && ((state == ST_IDLE) || in_frame))
            || ((state == ST_IDLE) && rx_valid && !cmd_ok)
            || timeout;
  end

  // ---------------- parser datapath ----------------
  // Address and data arrive LSB first, so each byte is shifted in from the top.
  // resp_data holds the queued response; byte 0 is always in [7:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= 2'd0;
      is_rd     <= 1'b0;
      addr_sh   <= 32'd0;
      data_sh   <= 32'd0;
      wr_addr_o <= 32'd0;
      wr_data_o <= 32'd0;
      rd_addr_o <= 32'd0;
      resp_data <= 32'd0;
      resp_rem  <= 2'd0;
      wait_cnt  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          byte_cnt <= 2'd0;
          if (rx_valid) begin
            is_rd <= (rx_data == CMD_READ);
            if (!cmd_ok) begin
              resp_data <= {24'd0, RESP_NAK};
              resp_rem  <= 2'd0;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (timeout) begin
            resp_data <= {24'd0, RESP_NAK};
            resp_rem  <= 2'd0;
          end else if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            wait_cnt <= 8'd0;
            if (state == ST_ADDR) begin
              addr_sh <= {rx_data, addr_sh[31:8]};
              if ((byte_cnt == 2'd3) && is_rd) begin
                rd_addr_o <= {rx_data, addr_sh[31:8]};
              end
            end else begin
              data_sh <= {rx_data, data_sh[31:8]};
              if (byte_cnt == 2'd3) begin
                wr_addr_o <= addr_sh;
                wr_data_o <= {rx_data, data_sh[31:8]};
              end
            end
          end
        end
        ST_WRITE: begin
          resp_data <= {24'd0, RESP_ACK};
          resp_rem  <= 2'd0;
        end
        ST_RD_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (wait_cnt == RD_WAIT_LAST) begin
            resp_data <= rd_data_i;
            resp_rem  <= 2'd3;
          end
        end
        ST_RESP: begin
          if (tx_byte_done) begin
            resp_data <= {8'd0, resp_data[31:8]};
            if (resp_rem != 2'd0) begin
              resp_rem <= resp_rem - 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- TX serialiser ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= 16'd0;
      tx_bit    <= 3'd0;
      tx_done_q <= 1'b0;
    end else begin
      tx_state  <= tx_next;
      tx_done_q <= tx_byte_done && (resp_rem == 2'd0);
      if ((tx_state == TX_IDLE) || (tx_cnt == BAUD_LAST)) begin
        tx_cnt <= 16'd0;
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
      if (tx_state != TX_DATA) begin
        tx_bit <= 3'd0;
      end else if (tx_cnt == BAUD_LAST) begin
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end

  // A response starts on the first RESP cycle; tx_done_q blocks a restart
  // during the final RESP cycle after the last byte.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: begin
        if ((state == ST_RESP) && !tx_done_q) begin
          tx_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BAUD_LAST) begin
          tx_next = TX_DATA;
        end
      end
      TX_DATA: begin
        if ((tx_cnt == BAUD_LAST) && (tx_bit == 3'd7)) begin
          tx_next = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BAUD_LAST) begin
          tx_next = (resp_rem == 2'd0) ? TX_IDLE : TX_START;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = resp_data[tx_bit];
      default:  uart_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_dbg_master.sv
// tb/tb_uart_dbg_master.sv - directed self-checking bench for uart_dbg_master
`timescale 1ns/1ps
module tb_uart_dbg_master;

  localparam int BIT = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        uart_tx;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic [31:0] rd_addr_o;
  logic [31:0] rd_data_i = 32'd0;
  logic        busy_o;
  logic        err_o;

  always #5 clk = ~clk;

  uart_dbg_master #(
    .CLK_FREQ  (1000000),
    .UART_BPS  (100000),
    .RD_LATENCY(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .wr_en_o  (wr_en_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  int checks   = 0;
  int failures = 0;

  int          cyc = 0;
  int          wr_cnt = 0;
  int          err_cnt = 0;
  int          busy_fall_cyc = 0;
  int          last_stop_cyc = 0;
  int          tx_stop_errs = 0;
  logic        busy_q = 1'b0;
  logic [31:0] wr_addr_seen = 32'd0;
  logic [31:0] wr_data_seen = 32'd0;
  logic [7:0]  txq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // bus slave: one-cycle read latency
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rd_data_i <= (rd_addr_o == 32'h1000_0004) ? 32'h1234_5678 : (32'hA5A5_0000 ^ rd_addr_o);
  end

  always @(negedge clk) begin
    if (wr_en_o) begin
      wr_cnt       <= wr_cnt + 1;
      wr_addr_seen <= wr_addr_o;
      wr_data_seen <= wr_data_o;
    end
    if (err_o) err_cnt <= err_cnt + 1;
    if (busy_q && !busy_o) busy_fall_cyc <= cyc;
    busy_q <= busy_o;
  end

  // decode uart_tx into txq, sampling mid-bit on falling clock edges
  initial begin : tx_mon
    logic [7:0] b;
    b = 8'd0;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (BIT) @(negedge clk);
        if (uart_tx !== 1'b1) tx_stop_errs++;
        last_stop_cyc = cyc;
        txq.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // first byte of the frame sits in the most significant used byte of f
  task automatic send_frame(input logic [71:0] f, input int n);
    logic [71:0] t;
    for (int i = 0; i < n; i++) begin
      t = f >> (8 * (n - 1 - i));
      send_byte(t[7:0], 1'b1);
    end
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && txq.size() < n; i++) @(negedge clk);
  endtask

  function automatic logic [31:0] pop_tx();
    if (txq.size() == 0) return 32'hFFFF_FFFF;
    return {24'd0, txq.pop_front()};
  endfunction

  int err0;
  int wr0;

  initial begin
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_err", err_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_rd_addr", rd_addr_o, 0);
    rst = 1'b0;
    repeat (3 * BIT) @(negedge clk);

    // write frame
    err0 = err_cnt;
    send_frame(72'h57_10_00_00_80_EF_BE_AD_DE, 9);
    wait_tx(1, 400);
    check("wr_txlen", txq.size(), 1);
    check("wr_ack", pop_tx(), 32'h06);
    check("wr_count", wr_cnt, 1);
    check("wr_addr", wr_addr_seen, 32'h8000_0010);
    check("wr_data", wr_data_seen, 32'hDEAD_BEEF);
    check("wr_err", err_cnt - err0, 0);

    // read frame
    repeat (2 * BIT) @(negedge clk);
    send_frame(72'h52_04_00_00_10, 5);
    wait_tx(4, 800);
    check("rd_txlen", txq.size(), 4);
    check("rd_b0", pop_tx(), 32'h78);
    check("rd_b1", pop_tx(), 32'h56);
    check("rd_b2", pop_tx(), 32'h34);
    check("rd_b3", pop_tx(), 32'h12);
    repeat (BIT) @(negedge clk);
    check("rd_busy_fall", busy_fall_cyc - last_stop_cyc, 6);
    check("rd_busy", busy_o, 0);
    check("rd_addr_hold", rd_addr_o, 32'h1000_0004);
    check("wr_addr_hold", wr_addr_o, 32'h8000_0010);
    check("rd_no_wr", wr_cnt, 1);

    // bad command
    err0 = err_cnt;
    send_frame(72'h41, 1);
    wait_tx(1, 400);
    check("bad_nak", pop_tx(), 32'h15);
    check("bad_err", err_cnt - err0, 1);
    check("bad_no_wr", wr_cnt, 1);

    // framing error, then a valid write
    repeat (2 * BIT) @(negedge clk);
    err0 = err_cnt;
    send_byte(8'h57, 1'b0);
    repeat (4 * BIT) @(negedge clk);
    check("fe_err", err_cnt - err0, 1);
    check("fe_busy", busy_o, 0);
    check("fe_no_tx", txq.size(), 0);
    send_frame(72'h57_44_33_22_11_04_03_02_01, 9);
    wait_tx(1, 400);
    check("fe_ack", pop_tx(), 32'h06);
    check("fe_wr_count", wr_cnt, 2);
    check("fe_wr_addr", wr_addr_seen, 32'h1122_3344);
    check("fe_wr_data", wr_data_seen, 32'h0102_0304);

    // reset part-way through a write frame
    repeat (2 * BIT) @(negedge clk);
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_tx", uart_tx, 1);
    check("mr_busy", busy_o, 0);
    check("mr_wr_en", wr_en_o, 0);
    check("mr_wr_addr", wr_addr_o, 0);
    check("mr_rd_addr", rd_addr_o, 0);
    rst = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    check("mr_no_wr", wr_cnt, 2);
    check("mr_no_tx", txq.size(), 0);
    send_frame(72'h57_78_56_34_12_44_33_22_11, 9);
    wait_tx(1, 400);
    check("mr_ack", pop_tx(), 32'h06);
    check("mr_wr_count", wr_cnt, 3);
    check("mr_wr_addr", wr_addr_seen, 32'h1234_5678);
    check("mr_wr_data", wr_data_seen, 32'h1122_3344);

    // truncated frame: command and one address byte, then silence
    repeat (2 * BIT) @(negedge clk);
    err0 = err_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (200) @(negedge clk);
`ifdef UART_DBG_TIMEOUT_EN
    wait_tx(1, 400);
    check("to_txlen", txq.size(), 1);
    check("to_nak", pop_tx(), 32'h15);
    repeat (2 * BIT) @(negedge clk);
    check("to_err", err_cnt - err0, 1);
    check("to_busy", busy_o, 0);
`else
    repeat (400) @(negedge clk);
    check("to_no_tx", txq.size(), 0);
    check("to_no_err", err_cnt - err0, 0);
    check("to_busy", busy_o, 1);
`endif
    check("to_no_wr", wr_cnt, 3);
    check("tx_stop_bits", tx_stop_errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
